// File: rtl/bus_router.sv
// Single-master bus router: decodes the core request onto NDEV slaves, tracks one
// outstanding transaction, and always answers the core (slave data, error or timeout).
module bus_router #(
  parameter int NDEV      = 6,
  parameter int XLEN      = 32,
  parameter int BUS_WIDTH = 32,
  parameter int ACC_W     = 2,
  parameter logic [NDEV*XLEN-1:0] DEV_BASE = {32'h5000_0000, 32'h4000_0000, 32'h3000_0000,
                                               32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NDEV*XLEN-1:0] DEV_MASK = {32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFF00_0000,
                                               32'hFFF8_0000, 32'hFFFF_F000, 32'hFFFF_F000},
  parameter int TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      bus_req,
  input  logic [XLEN-1:0]           bus_addr,
  input  logic                      bus_w_rb,
  input  logic [ACC_W-1:0]          bus_acc,
  input  logic [BUS_WIDTH-1:0]      bus_wdata,
  output logic [BUS_WIDTH-1:0]      bus_rdata,
  output logic                      bus_resp,
  output logic                      busy,
  output logic                      bus_fault,
  output logic [XLEN-1:0]           bus_fault_addr,
  output logic [2:0]                bus_fault_cause,
  input  logic                      fault_clr,
  output logic [NDEV-1:0]           dev_req,
  output logic [XLEN-1:0]           dev_addr,
  output logic                      dev_w_rb,
  output logic [ACC_W-1:0]          dev_acc,
  output logic [BUS_WIDTH-1:0]      dev_wdata,
  input  logic [NDEV*BUS_WIDTH-1:0] dev_rdata,
  input  logic [NDEV-1:0]           dev_resp,
  input  logic [NDEV-1:0]           dev_fault
);

  localparam int SEL_W = (NDEV > 1) ? $clog2(NDEV) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] CAUSE_DECODE  = 3'd1;
  localparam logic [2:0] CAUSE_ALIGN   = 3'd2;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd3;
  localparam logic [2:0] CAUSE_DEV     = 3'd4;
  localparam logic [2:0] CAUSE_BUSY    = 3'd5;
  localparam logic [2:0] CAUSE_STRAY   = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]        addr_q, addr_d;
  logic                   fault_q, fault_d;
  logic [XLEN-1:0]        fault_addr_q, fault_addr_d;
  logic [2:0]             fault_cause_q, fault_cause_d;

  logic [NDEV-1:0]        hit_s, dec_oh_s, sel_oh_s;
  logic [SEL_W-1:0]       dec_idx_s;
  logic                   found_s, misalign_s;
  logic [XLEN-1:0]        mask_hit_s;
  logic [BUS_WIDTH-1:0]   rdata_sel_s;
  logic                   resp_sel_s, fault_sel_s;
  logic [CNT_W-1:0]       cnt_inc_s;
  logic                   decode_err_s, align_err_s, timeout_err_s, dev_err_s, busy_err_s, stray_err_s;
  logic                   fault_hit_s;
  logic [2:0]             cause_s;
  logic [XLEN-1:0]        cause_addr_s;

  assign dev_w_rb        = bus_w_rb;
  assign dev_acc         = bus_acc;
  assign dev_wdata       = bus_wdata;
  assign dev_addr        = bus_addr & ~mask_hit_s;
  assign busy            = (state_q != S_IDLE);
  assign bus_fault       = fault_q;
  assign bus_fault_addr  = fault_addr_q;
  assign bus_fault_cause = fault_cause_q;

  // Address decode; the lowest-numbered hitting device wins.
  always_comb begin
    hit_s      = '0;
    dec_oh_s   = '0;
    dec_idx_s  = '0;
    found_s    = 1'b0;
    mask_hit_s = '0;
    for (int i = 0; i < NDEV; i++) begin
      hit_s[i] = ((bus_addr & DEV_MASK[i*XLEN +: XLEN]) == DEV_BASE[i*XLEN +: XLEN]);
      if (hit_s[i] && !found_s) begin
        found_s     = 1'b1;
        dec_idx_s   = SEL_W'(i);
        dec_oh_s[i] = 1'b1;
        mask_hit_s  = DEV_MASK[i*XLEN +: XLEN];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Alignment check; size code 3 is reserved and always rejected.
  always_comb begin
    case (bus_acc)
      ACC_W'(0): misalign_s = 1'b0;
      ACC_W'(1): misalign_s = bus_addr[0];
      ACC_W'(2): misalign_s = (bus_addr[1:0] != 2'b00);
      default:   misalign_s = 1'b1;
    endcase
  end

  // Select the latched device's read data and strobes.
  always_comb begin
    sel_oh_s    = '0;
    rdata_sel_s = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (SEL_W'(i) == sel_q) begin
        sel_oh_s[i] = 1'b1;
        rdata_sel_s = dev_rdata[i*BUS_WIDTH +: BUS_WIDTH];
      end else begin
        sel_oh_s[i] = 1'b0;
      end
    end
    resp_sel_s  = |(dev_resp & sel_oh_s);
    fault_sel_s = |(dev_fault & sel_oh_s);
    cnt_inc_s   = cnt_q + CNT_W'(1);
  end

  // Transaction FSM next state, core/slave strobes and raw fault events.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    dev_req       = '0;
    bus_resp      = 1'b0;
    bus_rdata     = '0;
    decode_err_s  = 1'b0;
    align_err_s   = 1'b0;
    timeout_err_s = 1'b0;
    dev_err_s     = 1'b0;
    busy_err_s    = 1'b0;
    stray_err_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        stray_err_s = |dev_resp;
        if (bus_req) begin
          if (!found_s) begin
            decode_err_s = 1'b1;
            state_d      = S_ERR;
          end else if (misalign_s) begin
            align_err_s = 1'b1;
            state_d     = S_ERR;
          end else begin
            dev_req = dec_oh_s;
            sel_d   = dec_idx_s;
            cnt_d   = '0;
            addr_d  = bus_addr;
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d       = cnt_inc_s;
        bus_rdata   = rdata_sel_s;
        bus_resp    = resp_sel_s;
        dev_err_s   = fault_sel_s;
        busy_err_s  = bus_req;
        stray_err_s = |(dev_resp & ~sel_oh_s);
        // The count includes this cycle, so the abort lands TIMEOUT cycles after the request.
        if (resp_sel_s) begin
          state_d = S_IDLE;
        end else if (cnt_inc_s == CNT_W'(TIMEOUT)) begin
          bus_resp      = 1'b1;
          bus_rdata     = '0;
          timeout_err_s = 1'b1;
          state_d       = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ERR: begin
        bus_resp    = 1'b1;
        busy_err_s  = bus_req;
        stray_err_s = |dev_resp;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Fault prioritisation and sticky capture of the first fault only.
  always_comb begin
    fault_hit_s  = 1'b1;
    cause_s      = 3'd0;
    cause_addr_s = '0;
    if (decode_err_s) begin
      cause_s      = CAUSE_DECODE;
      cause_addr_s = bus_addr;
    end else if (align_err_s) begin
      cause_s      = CAUSE_ALIGN;
      cause_addr_s = bus_addr;
    end else if (timeout_err_s) begin
      cause_s      = CAUSE_TIMEOUT;
      cause_addr_s = addr_q;
    end else if (dev_err_s) begin
      cause_s      = CAUSE_DEV;
      cause_addr_s = addr_q;
    end else if (busy_err_s) begin
      cause_s      = CAUSE_BUSY;
      cause_addr_s = bus_addr;
    end else if (stray_err_s) begin
      cause_s      = CAUSE_STRAY;
      cause_addr_s = bus_addr;
    end else begin
      fault_hit_s = 1'b0;
    end

    fault_d       = fault_q;
    fault_addr_d  = fault_addr_q;
    fault_cause_d = fault_cause_q;
    if (fault_clr) begin
      fault_d       = 1'b0;
      fault_addr_d  = '0;
      fault_cause_d = 3'd0;
    end else begin
      fault_d = fault_q;
    end
    if (fault_hit_s && (!fault_q || fault_clr)) begin
      fault_d       = 1'b1;
      fault_addr_d  = cause_addr_s;
      fault_cause_d = cause_s;
    end else begin
      fault_d = fault_d;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      sel_q         <= '0;
      cnt_q         <= '0;
      addr_q        <= '0;
      fault_q       <= 1'b0;
      fault_addr_q  <= '0;
      fault_cause_q <= 3'd0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      fault_q       <= fault_d;
      fault_addr_q  <= fault_addr_d;
      fault_cause_q <= fault_cause_d;
    end
  end

endmodule

// File: tb/tb_bus_router.sv
// Directed bench for bus_router: expected read data queued at request time and
// popped when the router answers; fault record checked after each scenario.
module tb_bus_router;

  localparam int NDEV = 6;
  localparam int XLEN = 32;
  localparam int BW   = 32;

  logic              clk = 1'b0;
  logic              rstn;
  logic              bus_req;
  logic [XLEN-1:0]   bus_addr;
  logic              bus_w_rb;
  logic [1:0]        bus_acc;
  logic [BW-1:0]     bus_wdata;
  logic [BW-1:0]     bus_rdata;
  logic              bus_resp;
  logic              busy;
  logic              bus_fault;
  logic [XLEN-1:0]   bus_fault_addr;
  logic [2:0]        bus_fault_cause;
  logic              fault_clr;
  logic [NDEV-1:0]   dev_req;
  logic [XLEN-1:0]   dev_addr;
  logic              dev_w_rb;
  logic [1:0]        dev_acc;
  logic [BW-1:0]     dev_wdata;
  logic [NDEV*BW-1:0] dev_rdata;
  logic [NDEV-1:0]   dev_resp;
  logic [NDEV-1:0]   dev_fault;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  logic [31:0] exp_q[$];

  bus_router #(.TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn), .bus_req(bus_req), .bus_addr(bus_addr), .bus_w_rb(bus_w_rb),
    .bus_acc(bus_acc), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_resp(bus_resp),
    .busy(busy), .bus_fault(bus_fault), .bus_fault_addr(bus_fault_addr),
    .bus_fault_cause(bus_fault_cause), .fault_clr(fault_clr), .dev_req(dev_req),
    .dev_addr(dev_addr), .dev_w_rb(dev_w_rb), .dev_acc(dev_acc), .dev_wdata(dev_wdata),
    .dev_rdata(dev_rdata), .dev_resp(dev_resp), .dev_fault(dev_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet();
    bus_req   = 1'b0;
    dev_resp  = '0;
    dev_fault = '0;
    fault_clr = 1'b0;
  endtask

  task automatic request(input logic [31:0] addr, input logic [1:0] acc);
    bus_req  = 1'b1;
    bus_addr = addr;
    bus_acc  = acc;
  endtask

  task automatic respond(input int d, input logic [31:0] data);
    dev_resp[d]            = 1'b1;
    dev_rdata[d*BW +: BW]  = data;
  endtask

  task automatic check_resp(input string tag);
    logic [31:0] e;
    chk({tag, "_resp"}, 64'(bus_resp), 64'd1);
    if (bus_resp === 1'b1) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({tag, "_rdata"}, 64'(bus_rdata), 64'(e));
      end else begin
        total++;
        failed++;
        $error("FAIL %s_sb observed=response expected=no_pending_entry", tag);
      end
    end
  endtask

  task automatic check_fault(input string tag, input logic f, input logic [31:0] a, input logic [2:0] c);
    chk({tag, "_flag"}, 64'(bus_fault), 64'(f));
    chk({tag, "_addr"}, 64'(bus_fault_addr), 64'(a));
    chk({tag, "_cause"}, 64'(bus_fault_cause), 64'(c));
  endtask

  initial begin
    rstn      = 1'b0;
    bus_addr  = '0;
    bus_acc   = 2'd2;
    bus_w_rb  = 1'b0;
    bus_wdata = 32'h5555_AAAA;
    for (int d = 0; d < NDEV; d++) dev_rdata[d*BW +: BW] = 32'hA0A0_0000 | 32'(d);
    quiet();
    repeat (3) cyc();
    rstn = 1'b1;
    settle();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp", 64'(bus_resp), 64'd0);
    chk("rst_devreq", 64'(dev_req), 64'd0);
    check_fault("rst", 1'b0, 32'h0, 3'd0);

    // TCM read, slave answers three cycles after the request
    cyc();
    request(32'h1000_0004, 2'd2);
    exp_q.push_back(32'hDEAD_BEEF);
    settle();
    chk("tcm_devreq", 64'(dev_req), 64'b000010);
    chk("tcm_devaddr", 64'(dev_addr), 64'h004);
    chk("tcm_wrb", 64'(dev_w_rb), 64'd0);
    cyc(); quiet(); settle();
    chk("tcm_busy", 64'(busy), 64'd1);
    chk("tcm_noresp1", 64'(bus_resp), 64'd0);
    cyc(); settle();
    chk("tcm_noresp2", 64'(bus_resp), 64'd0);
    cyc(); respond(1, 32'hDEAD_BEEF); settle();
    check_resp("tcm");
    cyc(); quiet(); settle();
    chk("tcm_idle", 64'(busy), 64'd0);
    check_fault("tcm", 1'b0, 32'h0, 3'd0);

    // Unmapped address
    request(32'h6000_0000, 2'd2);
    exp_q.push_back(32'h0);
    settle();
    chk("miss_devreq", 64'(dev_req), 64'd0);
    cyc(); quiet(); settle();
    check_resp("miss");
    check_fault("miss", 1'b1, 32'h6000_0000, 3'd1);
    fault_clr = 1'b1;
    cyc(); quiet(); settle();
    check_fault("miss_clr", 1'b0, 32'h0, 3'd0);

    // Misaligned halfword, then an aligned one to SRAM
    request(32'h2000_0001, 2'd1);
    exp_q.push_back(32'h0);
    settle();
    chk("align_devreq", 64'(dev_req), 64'd0);
    cyc(); quiet(); settle();
    check_resp("align");
    check_fault("align", 1'b1, 32'h2000_0001, 3'd2);
    fault_clr = 1'b1;
    cyc(); quiet(); settle();
    chk("align_clr", 64'(bus_fault), 64'd0);
    request(32'h2000_0002, 2'd1);
    exp_q.push_back(32'h1234_5678);
    settle();
    chk("half_devreq", 64'(dev_req), 64'b000100);
    chk("half_devaddr", 64'(dev_addr), 64'h2);
    chk("half_acc", 64'(dev_acc), 64'd1);
    cyc(); quiet(); respond(2, 32'h1234_5678); settle();
    check_resp("half");
    cyc(); quiet(); settle();

    // UART never answers
    request(32'h5000_0000, 2'd2);
    exp_q.push_back(32'h0);
    settle();
    chk("uart_devreq", 64'(dev_req), 64'b100000);
    for (int k = 1; k < 8; k++) begin
      cyc(); quiet(); settle();
      chk($sformatf("uart_wait%0d", k), 64'(bus_resp), 64'd0);
    end
    cyc(); settle();
    check_resp("uart_to");
    cyc(); respond(5, 32'h7777_7777); settle();
    check_fault("uart_to", 1'b1, 32'h5000_0000, 3'd3);
    chk("uart_to_idle", 64'(busy), 64'd0);
    cyc(); quiet(); settle();
    chk("late_sticky", 64'(bus_fault_cause), 64'd3);
    fault_clr = 1'b1;
    cyc(); quiet(); bus_addr = 32'h0ABC_0000; respond(5, 32'h7777_7777); settle();
    cyc(); quiet(); settle();
    check_fault("stray", 1'b1, 32'h0ABC_0000, 3'd6);
    fault_clr = 1'b1;
    cyc(); quiet(); settle();

    // Second request while SRAM is outstanding
    request(32'h2000_0010, 2'd2);
    exp_q.push_back(32'hCAFE_F00D);
    cyc(); request(32'h1000_0000, 2'd2); settle();
    chk("busy_devreq", 64'(dev_req), 64'd0);
    chk("busy_noresp", 64'(bus_resp), 64'd0);
    cyc(); quiet(); respond(2, 32'hCAFE_F00D); settle();
    check_fault("busy", 1'b1, 32'h1000_0000, 3'd5);
    check_resp("busy_sram");
    fault_clr = 1'b1;
    cyc(); quiet(); settle();

    // Slave fault on the selected device still completes
    request(32'h1000_0008, 2'd2);
    exp_q.push_back(32'h0BAD_0001);
    cyc(); quiet(); respond(1, 32'h0BAD_0001); dev_fault[1] = 1'b1; settle();
    check_resp("devflt");
    cyc(); quiet(); settle();
    check_fault("devflt", 1'b1, 32'h1000_0008, 3'd4);
    fault_clr = 1'b1;
    cyc(); quiet(); settle();

    // Response arrives in the timeout cycle
    request(32'h0000_0100, 2'd2);
    exp_q.push_back(32'h0BAD_CAFE);
    for (int k = 1; k < 8; k++) begin
      cyc(); quiet(); settle();
      chk($sformatf("race_wait%0d", k), 64'(bus_resp), 64'd0);
    end
    cyc(); respond(0, 32'h0BAD_CAFE); settle();
    check_resp("race");
    cyc(); quiet(); settle();
    check_fault("race", 1'b0, 32'h0, 3'd0);

    // Reset while waiting, then the slave answers late
    request(32'h3000_0000, 2'd2);
    cyc(); quiet(); settle();
    chk("rstw_busy", 64'(busy), 64'd1);
    rstn = 1'b0;
    cyc(); settle();
    chk("rstw_idle", 64'(busy), 64'd0);
    rstn = 1'b1;
    respond(3, 32'h3333_3333);
    cyc(); quiet(); settle();
    check_fault("rstw_stray", 1'b1, 32'h3000_0000, 3'd6);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bus_router.md
Name: bus_router

Overview:
- Parametrised successor to the fixed single-master bus decoder: NDEV slaves, address map set by per-device BASE/MASK parameters.
- Adds tracking of one outstanding transaction, a response timeout watchdog, error responses so the core never hangs, and a sticky fault record with cause code and clear.
- Sits between the core bus port and the memory/peripheral controllers (ROM, TCM, SRAM, QSPI NOR, GPIO, UART).

Parameters:
- NDEV, 6, number of slave devices.
- XLEN, 32, address width.
- BUS_WIDTH, 32, data width.
- ACC_W, 2, access-size code width (0=1B, 1=2B, 2=4B).
- DEV_BASE, {NDEV x XLEN} packed; device i at bits [i*XLEN +: XLEN]; default 0x00000000, 0x10000000, 0x20000000, 0x30000000, 0x40000000, 0x50000000.
- DEV_MASK, {NDEV x XLEN} packed; 1 = decoded bit; default 0xFFFFF000, 0xFFFFF000, 0xFFF80000, 0xFF000000, 0xFFFFFFF8, 0xFFFFFFFC.
- TIMEOUT, 255, wait cycles before abort; range 1..65535.

Ports:
- clk, in, 1, clock.
- rstn, in, 1, synchronous reset, active low.
- bus_req, in, 1, single-cycle request strobe from core.
- bus_addr, in, XLEN, request address.
- bus_w_rb, in, 1, 1=write 0=read.
- bus_acc, in, ACC_W, access size.
- bus_wdata, in, BUS_WIDTH, write data.
- bus_rdata, out, BUS_WIDTH, read data, valid with bus_resp.
- bus_resp, out, 1, single-cycle completion strobe.
- busy, out, 1, transaction outstanding.
- bus_fault, out, 1, sticky fault flag.
- bus_fault_addr, out, XLEN, address of first fault.
- bus_fault_cause, out, 3, cause of first fault.
- fault_clr, in, 1, clears fault record.
- dev_req, out, NDEV, one-hot request strobes.
- dev_addr, out, XLEN, bus_addr & ~DEV_MASK[sel] (offset within device).
- dev_w_rb, out, 1, passthrough of bus_w_rb.
- dev_acc, out, ACC_W, passthrough of bus_acc.
- dev_wdata, out, BUS_WIDTH, passthrough of bus_wdata.
- dev_rdata, in, NDEV x BUS_WIDTH, packed slave read data.
- dev_resp, in, NDEV, slave response strobes.
- dev_fault, in, NDEV, slave fault strobes.

Behaviour:
- Reset: state IDLE, busy=0, bus_resp=0, dev_req=0, bus_fault=0, bus_fault_addr=0, bus_fault_cause=0, timeout counter=0, sel=0.
- Decode (combinational): hit_i = ((bus_addr & MASK_i) == BASE_i). Lowest hitting index wins. Miss = no hit.
- Misalignment: acc=1 with addr[0]=1, or acc=2 with addr[1:0]!=0. acc=3 is treated as misaligned.
- FSM states are IDLE, WAIT, ERR.
- IDLE + bus_req + hit + aligned:
  - dev_req[sel] = 1 in the same cycle (combinational).
  - Latch sel, clear counter, go to WAIT. busy=1 from the next cycle.
- IDLE + bus_req + (miss or misaligned):
  - No dev_req is issued.
  - Go to ERR and log the fault: DECODE=1 if miss, else ALIGN=2. Miss takes precedence.
- ERR: bus_resp=1 and bus_rdata=0 for exactly one cycle (the cycle after the request), then go to IDLE.
- WAIT:
  - bus_rdata = dev_rdata[sel].
  - bus_resp = dev_resp[sel] combinationally, so there is zero added latency.
  - On dev_resp[sel], go to IDLE. A new req is accepted the following cycle.
  - Counter increments every WAIT cycle. When counter==TIMEOUT with no resp:
    - bus_resp=1 and rdata=0 in that cycle.
    - Log TIMEOUT=3 and go to IDLE.
  - A resp in the same cycle as the timeout wins; no timeout is logged.
- dev_fault[sel] in WAIT logs DEV=4. The transaction still completes normally on resp. dev_fault from an unselected device is ignored.
- bus_req while busy (WAIT or ERR): not forwarded, no response, logs BUSY=5.
- dev_resp[j] with j!=sel, or any dev_resp in IDLE/ERR: ignored, logs STRAY=6. This covers a late response after a timeout.
- Fault record:
  - Only the first fault is captured. addr/cause load only when bus_fault==0; bus_fault_addr = bus_addr of the faulting request, or of the current bus_addr for STRAY.
  - Same-cycle priority: DECODE > ALIGN > TIMEOUT > DEV > BUSY > STRAY.
  - fault_clr clears flag, addr and cause next cycle. If a fault occurs in the same cycle as fault_clr, the new fault is captured.
- Reset mid-transaction: returns to IDLE next edge. Any later slave resp is flagged STRAY.
- Width rules:
  - Counter width = clog2(TIMEOUT+1).
  - sel width = clog2(NDEV), minimum 1.

Test Plan:
- Read 0x10000004, acc=2, TCM (dev1) resps 3 cycles later with 0xDEADBEEF:
  - dev_req=6'b000010 and dev_addr=0x004 in the request cycle.
  - bus_resp with 0xDEADBEEF 3 cycles later; no fault.
- Read 0x60000000 (unmapped): no dev_req; bus_resp with rdata=0 the next cycle; bus_fault=1, addr=0x60000000, cause=1.
- acc=1 at 0x20000001: ERR response the next cycle, cause=2. Then fault_clr → bus_fault=0. Then acc=1 at 0x20000002 reaches dev2 with dev_addr=0x2.
- UART (dev5) never responds, TIMEOUT=8: bus_resp with rdata=0 exactly 8 WAIT cycles after the request, cause=3. A late dev_resp[5] is flagged only if the fault was cleared first (cause=6).
- Second bus_req while waiting on SRAM: not forwarded, cause=5. The original SRAM resp still completes normally.
- Simultaneous TIMEOUT and dev_resp[sel]: normal completion with slave data, no fault. Assert rstn=0 in WAIT → busy=0 next cycle.
